// File: rtl/operand_stage.sv
// ID->EX operand stage: resolves source operands (forwarding or stalling) and holds the ID/EX
// pipeline register with valid/ready flow control. Define OPERAND_FWD_EN to enable forwarding.
module operand_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned PC_W   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [PC_W-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [XLEN-1:0]   rf_rd1,
    input  logic [XLEN-1:0]   rf_rd2,
    input  logic              exm_valid,
    input  logic              exm_reg_write,
    input  logic              exm_mem_read,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [XLEN-1:0]   exm_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_op_a,
    output logic [XLEN-1:0]   ex_op_b,
    output logic [XLEN-1:0]   ex_imm,
    output logic [PC_W-1:0]   ex_pc,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read
);

    logic            hazard;
    logic            adv;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;

    // x0 always reads as zero, even if the register file holds something else there.
    function automatic logic [XLEN-1:0] select_operand(input logic [REG_AW-1:0] rs,
                                                       input logic [XLEN-1:0]   rf);
        if (rs == '0) return '0;
`ifdef OPERAND_FWD_EN
        if (exm_valid && exm_reg_write && !exm_mem_read && exm_rd == rs) return exm_result;
        if (wb_reg_write && wb_rd == rs) return wb_data;
`endif
        return rf;
    endfunction

    function automatic logic src_hazard(input logic use_rs, input logic [REG_AW-1:0] rs);
        logic hz;
        hz = ex_valid && ex_reg_write && ex_rd == rs;
`ifdef OPERAND_FWD_EN
        hz = hz || (exm_valid && exm_reg_write && exm_mem_read && exm_rd == rs);
`else
        // Without bypass paths, wait until the producer has landed in the register file.
        hz = hz || (exm_valid && exm_reg_write && exm_rd == rs) ||
             (wb_reg_write && wb_rd == rs);
`endif
        return use_rs && (rs != '0) && hz;
    endfunction

`ifndef OPERAND_FWD_EN
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{exm_result, exm_mem_read, wb_data};
`endif

    always_comb begin
        hazard   = src_hazard(id_use_rs1, id_rs1) || src_hazard(id_use_rs2, id_rs2);
        adv      = !ex_valid || ex_ready;
        id_ready = flush || (adv && !hazard);
        op_a     = select_operand(id_rs1, rf_rd1);
        op_b     = select_operand(id_rs2, rf_rd2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid     <= 1'b0;
            ex_op_a      <= '0;
            ex_op_b      <= '0;
            ex_imm       <= '0;
            ex_pc        <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (adv) begin
            if (id_valid && !hazard) begin
                ex_valid     <= 1'b1;
                ex_op_a      <= op_a;
                ex_op_b      <= op_b;
                ex_imm       <= id_imm;
                ex_pc        <= id_pc;
                ex_rd        <= id_rd;
                ex_reg_write <= id_reg_write;
                ex_mem_read  <= id_mem_read;
            end else begin
                // Bubble: data fields keep their old values, only valid drops.
                ex_valid <= 1'b0;
            end
        end
    end

endmodule
